// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD conversion path.
// No logic of its own; imported by the converter and its digit adjuster.
package stopwatch_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   // Largest value representable in n BCD digits, kept at 32 bits for safe compares.
   function automatic logic [31:0] dec_max(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, 4-bit wrap.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adjust
   import stopwatch_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   bcd_digit_t plus3;

   assign plus3    = digit + 4'd3;
   assign adjusted = (digit >= 4'd5) ? plus3 : digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock; done pulses
// BIN_WIDTH+1 cycles after start is taken. start is dropped while busy (no queuing).
module binary_to_bcd_seq
   import stopwatch_pkg::*;
#(
   parameter int BIN_WIDTH = 7,
   parameter int DIGITS    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_WIDTH-1:0]  bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int                SW      = 4*DIGITS + BIN_WIDTH;
   localparam int                CNT_W   = $clog2(BIN_WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(BIN_WIDTH - 1);
   localparam logic [31:0]       MAX_VAL = dec_max(DIGITS);

   conv_state_t            state;
   conv_state_t            next_state;
   logic [BIN_WIDTH-1:0]   shreg;
   logic [4*DIGITS-1:0]    scratch;
   logic [4*DIGITS-1:0]    adj;
   logic [CNT_W-1:0]       cnt;
   logic                   ovf_hold;
   logic [SW-1:0]          shifted;
   logic                   accept;
   logic                   last_shift;
   logic                   ovf_new;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit    (scratch[4*g +: 4]),
         .adjusted (adj[4*g +: 4])
      );
   end

   // Any carry out of the top digit falls off here; saturation covers those cases.
   assign shifted = {adj, shreg} << 1;
   assign ovf_new = 32'(bin) > MAX_VAL;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      last_shift = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               last_shift = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         ovf_hold <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         shreg    <= bin;
         scratch  <= '0;
         cnt      <= '0;
         ovf_hold <= ovf_new;
      end else if (state == SHIFT) begin
         shreg   <= shifted[BIN_WIDTH-1:0];
         scratch <= shifted[SW-1:BIN_WIDTH];
         cnt     <= cnt + CNT_W'(1);
         if (last_shift) begin
            bcd      <= ovf_hold ? {DIGITS{4'h9}} : shifted[SW-1:BIN_WIDTH];
            overflow <= ovf_hold;
         end
      end
   end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq at default width and at BIN_WIDTH=10, DIGITS=3.
module tb_binary_to_bcd_seq;

   typedef struct packed {
      logic [7:0] bcd;
      logic       ov;
   } exp_t;

   typedef struct packed {
      logic [11:0] bcd;
      logic        ov;
   } expw_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [6:0]  bin;
   logic [7:0]  bcd;
   logic        busy;
   logic        done;
   logic        overflow;

   logic        start_w;
   logic [9:0]  bin_w;
   logic [11:0] bcd_w;
   logic        busy_w;
   logic        done_w;
   logic        overflow_w;

   int          errors;
   int          checks;
   exp_t        q[$];
   expw_t       qw[$];

   binary_to_bcd_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bin      (bin),
      .bcd      (bcd),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   binary_to_bcd_seq #(.BIN_WIDTH(10), .DIGITS(3)) dut_w (
      .clk      (clk),
      .rst      (rst),
      .start    (start_w),
      .bin      (bin_w),
      .bcd      (bcd_w),
      .busy     (busy_w),
      .done     (done_w),
      .overflow (overflow_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before 400000");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic exp_push(input logic [7:0] b, input logic o);
      exp_t x;
      x.bcd = b;
      x.ov  = o;
      q.push_back(x);
   endtask

   task automatic expw_push(input logic [11:0] b, input logic o);
      expw_t x;
      x.bcd = b;
      x.ov  = o;
      qw.push_back(x);
   endtask

   task automatic go(input logic [6:0] v);
      bin   = v;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic go_w(input logic [9:0] v);
      bin_w   = v;
      start_w = 1'b1;
      @(posedge clk);
      #1 start_w = 1'b0;
   endtask

   // Counts falling edges until done is seen; n is 1 for the falling edge after the start edge.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done in %0d cycles, required done", n);
      end
   endtask

   task automatic wait_done_w(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_w && n < 40);
      if (!done_w) begin
         checks++;
         errors++;
         $display("FAIL done_w_timeout: no done in %0d cycles, required done", n);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: bcd=%h ovf=%b, required no done", bcd, overflow);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (bcd !== e.bcd || overflow !== e.ov) begin
               errors++;
               $display("FAIL result: bcd=%h ovf=%b, required bcd=%h ovf=%b",
                        bcd, overflow, e.bcd, e.ov);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done_w) begin
         checks++;
         if (qw.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done_w: bcd=%h ovf=%b, required no done", bcd_w, overflow_w);
         end else begin
            expw_t e;
            e = qw.pop_front();
            if (bcd_w !== e.bcd || overflow_w !== e.ov) begin
               errors++;
               $display("FAIL result_w: bcd=%h ovf=%b, required bcd=%h ovf=%b",
                        bcd_w, overflow_w, e.bcd, e.ov);
            end
         end
      end
   end

   initial begin
      int   n;
      logic busy_ok;
      logic seen;
      logic [3:0] tens;
      logic [3:0] ones;

      errors  = 0;
      checks  = 0;
      rst     = 1'b1;
      start   = 1'b0;
      bin     = '0;
      start_w = 1'b0;
      bin_w   = '0;

      repeat (2) @(negedge clk);
      chk("reset_bcd", 32'(bcd), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_ovf", 32'(overflow), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Latency and handshake shape for bin=59
      exp_push(8'h59, 1'b0);
      go(7'd59);
      busy_ok = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (!busy || done) busy_ok = 1'b0;
      end
      chk("busy_7_cycles", 32'(busy_ok), 32'h1);
      @(negedge clk);
      chk("done_after_edge7", 32'(done), 32'h1);
      chk("busy_low_in_done", 32'(busy), 32'h0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'h0);

      // Full in-range sweep, back-to-back
      for (int v = 0; v < 100; v++) begin
         tens = 4'(v / 10);
         ones = 4'(v % 10);
         exp_push({tens, ones}, 1'b0);
         go(7'(v));
         wait_done(n);
         if (v == 0)  chk("bcd_0", 32'(bcd), 32'h00);
         if (v == 9)  chk("bcd_9", 32'(bcd), 32'h09);
         if (v == 10) chk("bcd_10", 32'(bcd), 32'h10);
         if (v == 99) begin
            chk("bcd_99", 32'(bcd), 32'h99);
            chk("sweep_latency", 32'(n), 32'd8);
         end
      end

      // Overflow saturation and recovery
      exp_push(8'h99, 1'b1);
      go(7'd100);
      wait_done(n);
      exp_push(8'h99, 1'b1);
      go(7'd127);
      wait_done(n);
      chk("ovf_127", 32'(overflow), 32'h1);
      exp_push(8'h42, 1'b0);
      go(7'd42);
      wait_done(n);
      chk("ovf_cleared", 32'(overflow), 32'h0);
      @(negedge clk);

      // start while busy is ignored; start in DONE chains with no idle gap
      exp_push(8'h25, 1'b0);
      go(7'd25);
      @(posedge clk);
      @(posedge clk);
      #1;
      bin   = 7'd77;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n);
      chk("ignore_latency", 32'(n), 32'd5);
      chk("ignore_bcd", 32'(bcd), 32'h25);
      exp_push(8'h77, 1'b0);
      go(7'd77);
      chk("no_idle_gap", 32'(busy), 32'h1);
      wait_done(n);
      chk("b2b_latency", 32'(n), 32'd8);

      // Leave nonzero outputs behind, then reset mid-conversion
      exp_push(8'h99, 1'b1);
      go(7'd127);
      wait_done(n);
      @(negedge clk);
      go(7'd88);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_bcd", 32'(bcd), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("no_done_after_rst", 32'(seen), 32'h0);
      exp_push(8'h13, 1'b0);
      go(7'd13);
      wait_done(n);
      chk("post_rst_bcd", 32'(bcd), 32'h13);

      // Wide instance: 10-bit input, 3 digits
      @(negedge clk);
      expw_push(12'h999, 1'b0);
      go_w(10'd999);
      wait_done_w(n);
      chk("wide_latency", 32'(n), 32'd11);
      expw_push(12'h999, 1'b1);
      go_w(10'd1023);
      wait_done_w(n);
      chk("wide_ovf", 32'(overflow_w), 32'h1);
      expw_push(12'h512, 1'b0);
      go_w(10'd512);
      wait_done_w(n);
      @(negedge clk);
      @(negedge clk);

      chk("queue_drained", 32'(q.size()), 32'd0);
      chk("queue_w_drained", 32'(qw.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
